// File: rtl/usb_std_request_ctrl.sv
// ============================================================================
// usb_std_request_ctrl : EP0 standard-request decoder, IN byte streamer and
//                        device-state holder (address, configuration, alts).
// Revision 2.0
// ============================================================================
`default_nettype none

module usb_std_request_ctrl #(
  parameter logic [143:0] DEVICE_DESC = '0,
  parameter int CONFIG_DESC_LEN = 18,
  parameter logic [8*CONFIG_DESC_LEN-1:0] CONFIG_DESC =
    144'h000000_FF_000000_04_09_32_80_00_01_01_00_12_02_09,
  parameter int STR_COUNT = 0,
  parameter int STR_DESC_LEN = 0,
  parameter logic [8*((STR_DESC_LEN > 0) ? STR_DESC_LEN : 1)-1:0] STR_DESC = '0,
  parameter logic [16*((STR_COUNT > 0) ? STR_COUNT : 1)-1:0] STR_OFFSETS = '0,
  parameter int NUM_IFACES = 1,
  parameter int MAX_ALT = 0,
  parameter logic [7:0] CONFIG_VALUE = 8'h01,
  parameter bit SELF_POWERED = 1'b1,
  parameter bit HIGH_SPEED = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [3:0]              ctl_xfer_endpoint,
  input  logic [7:0]              ctl_xfer_type,
  input  logic [7:0]              ctl_xfer_request,
  input  logic [15:0]             ctl_xfer_value,
  input  logic [15:0]             ctl_xfer_index,
  input  logic [15:0]             ctl_xfer_length,
  input  logic                    ctl_xfer_req_i,
  output logic                    ctl_xfer_gnt_o,
  output logic                    ctl_xfer_stall_o,
  output logic                    ctl_tvalid_o,
  input  logic                    ctl_tready_i,
  output logic                    ctl_tlast_o,
  output logic [7:0]              ctl_tdata_o,
  output logic [6:0]              device_address,
  output logic [7:0]              current_configuration,
  output logic                    configured,
  output logic [4*NUM_IFACES-1:0] alt_settings_o,
  output logic                    remote_wakeup_o,
  output logic                    standard_request
);

  localparam int STR_BYTES = (STR_DESC_LEN > 0) ? STR_DESC_LEN : 1;
  localparam int STR_SLOTS = (STR_COUNT > 0) ? STR_COUNT : 1;

  localparam logic [7:0] REQ_GET_STATUS    = 8'd0;
  localparam logic [7:0] REQ_CLEAR_FEATURE = 8'd1;
  localparam logic [7:0] REQ_SET_FEATURE   = 8'd3;
  localparam logic [7:0] REQ_SET_ADDRESS   = 8'd5;
  localparam logic [7:0] REQ_GET_DESC      = 8'd6;
  localparam logic [7:0] REQ_GET_CONFIG    = 8'd8;
  localparam logic [7:0] REQ_SET_CONFIG    = 8'd9;
  localparam logic [7:0] REQ_GET_IFACE     = 8'd10;
  localparam logic [7:0] REQ_SET_IFACE     = 8'd11;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, HOLD = 2'd2, REJECT = 2'd3} state_t;
  typedef enum logic [2:0] {SRC_DEV = 3'd0, SRC_CFG = 3'd1, SRC_STR = 3'd2,
                            SRC_QUAL = 3'd3, SRC_IMM = 3'd4} src_t;
  typedef enum logic [2:0] {ACT_NONE = 3'd0, ACT_ADDR = 3'd1, ACT_CONFIG = 3'd2,
                            ACT_IFACE = 3'd3, ACT_WAKE = 3'd4} act_t;

  function automatic logic [7:0] dev_byte(input logic [15:0] i);
    dev_byte = 8'h00;
    for (int k = 0; k < 18; k++)
      if (i == 16'(k)) dev_byte = DEVICE_DESC[8*k +: 8];
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [15:0] i);
    cfg_byte = 8'h00;
    for (int k = 0; k < CONFIG_DESC_LEN; k++)
      if (i == 16'(k)) cfg_byte = CONFIG_DESC[8*k +: 8];
  endfunction

  function automatic logic [7:0] str_byte(input logic [15:0] i);
    str_byte = 8'h00;
    for (int k = 0; k < STR_BYTES; k++)
      if (i == 16'(k)) str_byte = STR_DESC[8*k +: 8];
  endfunction

  function automatic logic [15:0] str_off(input logic [7:0] n);
    str_off = 16'h0000;
    for (int k = 0; k < STR_SLOTS; k++)
      if (n == 8'(k)) str_off = STR_OFFSETS[16*k +: 16];
  endfunction

  // Device qualifier is synthesised from the device descriptor's bcdUSB/class fields.
  function automatic logic [7:0] qual_byte(input logic [15:0] i);
    case (i)
      16'd0:   qual_byte = 8'd10;
      16'd1:   qual_byte = 8'd6;
      16'd2:   qual_byte = DEVICE_DESC[23:16];
      16'd3:   qual_byte = DEVICE_DESC[31:24];
      16'd4:   qual_byte = DEVICE_DESC[39:32];
      16'd5:   qual_byte = DEVICE_DESC[47:40];
      16'd6:   qual_byte = DEVICE_DESC[55:48];
      16'd7:   qual_byte = DEVICE_DESC[63:56];
      16'd8:   qual_byte = 8'd1;
      default: qual_byte = 8'd0;
    endcase
  endfunction

  state_t      state, state_next, dec_state;
  src_t        src, dec_src;
  act_t        act, dec_act;
  logic [15:0] base, dec_base, len, dec_len, dec_srclen, ptr, imm, dec_imm;
  logic [7:0]  act_val, dec_val, act_idx, dec_idx;
  logic [15:0] str_base;
  logic        str_ok, iface_ok, start, handshake, last_beat;
  logic [3:0]  alt_sel;

  assign standard_request = (ctl_xfer_endpoint == 4'd0) && (ctl_xfer_type[6:5] == 2'b00);
  assign start     = (state == IDLE) && ctl_xfer_req_i && standard_request;
  assign handshake = (state == SEND) && ctl_tready_i;
  assign last_beat = (ptr == len - 16'd1);
  assign str_base  = str_off(ctl_xfer_value[7:0]);
  assign str_ok    = ({8'h00, ctl_xfer_value[7:0]} + 16'd1) <= 16'(STR_COUNT);
  assign iface_ok  = ctl_xfer_index < 16'(NUM_IFACES);

  always_comb begin
    alt_sel = 4'h0;
    for (int k = 0; k < NUM_IFACES; k++)
      if (ctl_xfer_index[7:0] == 8'(k)) alt_sel = alt_settings_o[4*k +: 4];
  end

  always_comb begin
    dec_state  = REJECT;
    dec_src    = SRC_IMM;
    dec_base   = 16'h0000;
    dec_srclen = 16'h0000;
    dec_imm    = 16'h0000;
    dec_act    = ACT_NONE;
    dec_val    = 8'h00;
    dec_idx    = 8'h00;
    case (ctl_xfer_request)
      REQ_GET_DESC: if (ctl_xfer_type == 8'h80) begin
        case (ctl_xfer_value[15:8])
          8'd1: begin dec_state = SEND; dec_src = SRC_DEV; dec_srclen = 16'd18; end
          8'd2: begin dec_state = SEND; dec_src = SRC_CFG; dec_srclen = 16'(CONFIG_DESC_LEN); end
          8'd3: if (str_ok) begin
            dec_state  = SEND;
            dec_src    = SRC_STR;
            dec_base   = str_base;
            dec_srclen = {8'h00, str_byte(str_base)};
          end
          8'd6: if (HIGH_SPEED) begin dec_state = SEND; dec_src = SRC_QUAL; dec_srclen = 16'd10; end
          default: ;
        endcase
      end
      REQ_GET_STATUS: begin
        dec_srclen = 16'd2;
        if (ctl_xfer_type == 8'h80) begin
          dec_state = SEND;
          dec_imm   = {8'h00, 6'b0, remote_wakeup_o, SELF_POWERED};
        end else if ((ctl_xfer_type == 8'h81 && iface_ok) ||
                     (ctl_xfer_type == 8'h82 && ctl_xfer_index[3:0] == 4'd0)) begin
          dec_state = SEND;
        end
      end
      REQ_GET_CONFIG: if (ctl_xfer_type == 8'h80) begin
        dec_state = SEND; dec_srclen = 16'd1; dec_imm = {8'h00, current_configuration};
      end
      REQ_GET_IFACE: if (ctl_xfer_type == 8'h81 && configured && iface_ok) begin
        dec_state = SEND; dec_srclen = 16'd1; dec_imm = {12'h000, alt_sel};
      end
      REQ_SET_ADDRESS: if (ctl_xfer_type == 8'h00 && ctl_xfer_value <= 16'd127 && !configured) begin
        dec_state = HOLD; dec_act = ACT_ADDR; dec_val = ctl_xfer_value[7:0];
      end
      REQ_SET_CONFIG: if (ctl_xfer_type == 8'h00 &&
                          (ctl_xfer_value[7:0] == 8'h00 || ctl_xfer_value[7:0] == CONFIG_VALUE)) begin
        dec_state = HOLD; dec_act = ACT_CONFIG; dec_val = ctl_xfer_value[7:0];
      end
      REQ_SET_IFACE: if (ctl_xfer_type == 8'h01 && configured && iface_ok &&
                         ctl_xfer_value <= 16'(MAX_ALT)) begin
        dec_state = HOLD; dec_act = ACT_IFACE;
        dec_val = ctl_xfer_value[7:0]; dec_idx = ctl_xfer_index[7:0];
      end
      REQ_SET_FEATURE, REQ_CLEAR_FEATURE: begin
        if (ctl_xfer_type == 8'h00 && ctl_xfer_value == 16'd1) begin
          dec_state = HOLD; dec_act = ACT_WAKE;
          dec_val = {7'b0, ctl_xfer_request == REQ_SET_FEATURE};
        end else if (ctl_xfer_type == 8'h02 && ctl_xfer_value == 16'd0 &&
                     ctl_xfer_index[3:0] == 4'd0) begin
          dec_state = HOLD;  // EP0 halt is accepted but has no effect
        end
      end
      default: ;
    endcase
    dec_len = (ctl_xfer_length < dec_srclen) ? ctl_xfer_length : dec_srclen;
    if (dec_state == SEND && dec_len == 16'd0) dec_state = HOLD;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctl_xfer_req_i && standard_request) state_next = dec_state;
      SEND:    if (!ctl_xfer_req_i) state_next = IDLE;
               else if (handshake && last_beat) state_next = HOLD;
      default: if (!ctl_xfer_req_i) state_next = IDLE;
    endcase
  end

  always_comb begin
    case (src)
      SRC_DEV:  ctl_tdata_o = dev_byte(ptr);
      SRC_CFG:  ctl_tdata_o = cfg_byte(ptr);
      SRC_STR:  ctl_tdata_o = str_byte(base + ptr);
      SRC_QUAL: ctl_tdata_o = qual_byte(ptr);
      default:  ctl_tdata_o = (ptr == 16'd0) ? imm[7:0] : imm[15:8];
    endcase
  end

  assign ctl_xfer_gnt_o   = (state == SEND) || (state == HOLD);
  assign ctl_xfer_stall_o = (state == REJECT);
  assign ctl_tvalid_o     = (state == SEND);
  assign ctl_tlast_o      = (state == SEND) && last_beat;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      src                   <= SRC_IMM;
      act                   <= ACT_NONE;
      base                  <= '0;
      len                   <= '0;
      ptr                   <= '0;
      imm                   <= '0;
      act_val               <= '0;
      act_idx               <= '0;
      device_address        <= '0;
      current_configuration <= '0;
      configured            <= 1'b0;
      alt_settings_o        <= '0;
      remote_wakeup_o       <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        src     <= dec_src;
        base    <= dec_base;
        len     <= dec_len;
        imm     <= dec_imm;
        act     <= dec_act;
        act_val <= dec_val;
        act_idx <= dec_idx;
        ptr     <= '0;
      end else if (handshake) begin
        ptr <= ptr + 16'd1;
      end
      // SET_* side effects land only once the status stage completes.
      if (state == HOLD && !ctl_xfer_req_i) begin
        case (act)
          ACT_ADDR:   device_address <= act_val[6:0];
          ACT_CONFIG: begin
            configured            <= (act_val != 8'h00);
            current_configuration <= act_val;
            alt_settings_o        <= '0;
          end
          ACT_IFACE:
            for (int k = 0; k < NUM_IFACES; k++)
              if (act_idx == 8'(k)) alt_settings_o[4*k +: 4] <= act_val[3:0];
          ACT_WAKE:   remote_wakeup_o <= act_val[0];
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_std_request_ctrl.sv
// ============================================================================
// tb_usb_std_request_ctrl : directed checks of the EP0 standard-request handler.
// Revision 2.0
// ============================================================================
`default_nettype none

module tb_usb_std_request_ctrl;

  localparam logic [143:0] DEV = 144'h2120_1F1E_1D1C_1B1A_1918_1716_1514_1312_1110;
  localparam logic [143:0] CFG = 144'h000000_FF_000000_04_09_32_80_00_01_01_00_12_02_09;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  ctl_xfer_endpoint = '0;
  logic [7:0]  ctl_xfer_type = '0, ctl_xfer_request = '0;
  logic [15:0] ctl_xfer_value = '0, ctl_xfer_index = '0, ctl_xfer_length = '0;
  logic        ctl_xfer_req_i = 1'b0, ctl_tready_i = 1'b0;
  logic        ctl_xfer_gnt_o, ctl_xfer_stall_o, ctl_tvalid_o, ctl_tlast_o;
  logic [7:0]  ctl_tdata_o, current_configuration, alt_settings_o;
  logic [6:0]  device_address;
  logic        configured, remote_wakeup_o, standard_request;

  int checks = 0;
  int errors = 0;
  logic [7:0] got_data [0:31];
  logic       got_last [0:31];
  int         nbeats;

  always #5 clock = ~clock;

  usb_std_request_ctrl #(
    .DEVICE_DESC(DEV), .CONFIG_DESC_LEN(18), .CONFIG_DESC(CFG),
    .STR_COUNT(1), .STR_DESC_LEN(4), .STR_DESC(32'h0409_0304), .STR_OFFSETS(16'h0000),
    .NUM_IFACES(2), .MAX_ALT(3), .CONFIG_VALUE(8'h01), .SELF_POWERED(1'b1), .HIGH_SPEED(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .ctl_xfer_endpoint(ctl_xfer_endpoint), .ctl_xfer_type(ctl_xfer_type),
    .ctl_xfer_request(ctl_xfer_request), .ctl_xfer_value(ctl_xfer_value),
    .ctl_xfer_index(ctl_xfer_index), .ctl_xfer_length(ctl_xfer_length),
    .ctl_xfer_req_i(ctl_xfer_req_i), .ctl_xfer_gnt_o(ctl_xfer_gnt_o),
    .ctl_xfer_stall_o(ctl_xfer_stall_o), .ctl_tvalid_o(ctl_tvalid_o),
    .ctl_tready_i(ctl_tready_i), .ctl_tlast_o(ctl_tlast_o), .ctl_tdata_o(ctl_tdata_o),
    .device_address(device_address), .current_configuration(current_configuration),
    .configured(configured), .alt_settings_o(alt_settings_o),
    .remote_wakeup_o(remote_wakeup_o), .standard_request(standard_request)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_req(input logic [7:0] t, input logic [7:0] r,
                           input logic [15:0] v, input logic [15:0] i, input logic [15:0] l);
    @(negedge clock);
    ctl_xfer_endpoint = 4'd0;
    ctl_xfer_type = t; ctl_xfer_request = r;
    ctl_xfer_value = v; ctl_xfer_index = i; ctl_xfer_length = l;
    ctl_xfer_req_i = 1'b1;
  endtask

  task automatic end_req();
    @(negedge clock);
    ctl_xfer_req_i = 1'b0;
    @(negedge clock);
  endtask

  // Records every accepted beat over a fixed window of cycles.
  task automatic collect(input int cycles);
    nbeats = 0;
    ctl_tready_i = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (ctl_tvalid_o && ctl_tready_i && nbeats < 32) begin
        got_data[nbeats] = ctl_tdata_o;
        got_last[nbeats] = ctl_tlast_o;
        nbeats++;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checks++; if (ctl_xfer_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", ctl_xfer_gnt_o); end
    checks++; if (ctl_xfer_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", ctl_xfer_stall_o); end
    checks++; if (ctl_tvalid_o !== 1'b0 || ctl_tlast_o !== 1'b0) begin errors++; $display("FAIL reset_stream: got %b%b expected 00", ctl_tvalid_o, ctl_tlast_o); end
    checks++; if (device_address !== 7'd0) begin errors++; $display("FAIL reset_addr: got %h expected 00", device_address); end
    checks++; if (current_configuration !== 8'd0 || configured !== 1'b0) begin errors++; $display("FAIL reset_config: got %h/%b expected 00/0", current_configuration, configured); end
    checks++; if (alt_settings_o !== 8'h00 || remote_wakeup_o !== 1'b0) begin errors++; $display("FAIL reset_alt_wake: got %h/%b expected 00/0", alt_settings_o, remote_wakeup_o); end
    checks++; if (standard_request !== 1'b1) begin errors++; $display("FAIL reset_stdreq: got %b expected 1", standard_request); end
  endtask

  task automatic test_get_device_desc();
    start_req(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040);
    #1;
    checks++; if (ctl_xfer_gnt_o !== 1'b0) begin errors++; $display("FAIL dev_gnt_early: got %b expected 0", ctl_xfer_gnt_o); end
    tick();
    checks++; if (ctl_xfer_gnt_o !== 1'b1 || ctl_xfer_stall_o !== 1'b0) begin errors++; $display("FAIL dev_gnt: got %b/%b expected 1/0", ctl_xfer_gnt_o, ctl_xfer_stall_o); end
    collect(24);
    checks++; if (nbeats !== 18) begin errors++; $display("FAIL dev_beats: got %0d expected 18", nbeats); end
    for (int i = 0; i < 18 && i < nbeats; i++) begin
      checks++; if (got_data[i] !== 8'(8'h10 + i) || got_last[i] !== (i == 17)) begin
        errors++; $display("FAIL dev_beat%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], 8'(8'h10 + i), (i == 17));
      end
    end
    checks++; if (ctl_tvalid_o !== 1'b0 || ctl_xfer_gnt_o !== 1'b1) begin errors++; $display("FAIL dev_after: got tvalid %b gnt %b expected 0/1", ctl_tvalid_o, ctl_xfer_gnt_o); end
    end_req();
    checks++; if (ctl_xfer_gnt_o !== 1'b0) begin errors++; $display("FAIL dev_gnt_drop: got %b expected 0", ctl_xfer_gnt_o); end
  endtask

  task automatic test_get_config_desc();
    logic [7:0] exp_c [0:8] = '{8'h09, 8'h02, 8'h12, 8'h00, 8'h01, 8'h01, 8'h00, 8'h80, 8'h32};
    start_req(8'h80, 8'h06, 16'h0200, 16'h0000, 16'h0009);
    tick();
    collect(14);
    checks++; if (nbeats !== 9) begin errors++; $display("FAIL cfg_beats: got %0d expected 9", nbeats); end
    for (int i = 0; i < 9 && i < nbeats; i++) begin
      checks++; if (got_data[i] !== exp_c[i] || got_last[i] !== (i == 8)) begin
        errors++; $display("FAIL cfg_beat%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_c[i], (i == 8));
      end
    end
    end_req();
    start_req(8'h80, 8'h06, 16'h0200, 16'h0000, 16'h0000);
    tick();
    checks++; if (ctl_xfer_gnt_o !== 1'b1 || ctl_xfer_stall_o !== 1'b0) begin errors++; $display("FAIL cfg_len0_gnt: got %b/%b expected 1/0", ctl_xfer_gnt_o, ctl_xfer_stall_o); end
    collect(5);
    checks++; if (nbeats !== 0) begin errors++; $display("FAIL cfg_len0_beats: got %0d expected 0", nbeats); end
    end_req();
  endtask

  task automatic test_backpressure();
    ctl_tready_i = 1'b0;
    start_req(8'h80, 8'h06, 16'h0200, 16'h0000, 16'h0003);
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++; if (ctl_tvalid_o !== 1'b1 || ctl_tdata_o !== 8'h09) begin errors++; $display("FAIL bp_hold%0d: got %b/%h expected 1/09", c, ctl_tvalid_o, ctl_tdata_o); end
      tick();
    end
    collect(6);
    checks++; if (nbeats !== 3 || got_data[1] !== 8'h02 || got_data[2] !== 8'h12 || got_last[2] !== 1'b1 || got_last[1] !== 1'b0) begin
      errors++; $display("FAIL bp_stream: got %0d beats %h %h last %b expected 3 beats 02 12 last 1", nbeats, got_data[1], got_data[2], got_last[2]);
    end
    end_req();
  endtask

  task automatic test_strings();
    logic [7:0] exp_s [0:3] = '{8'h04, 8'h03, 8'h09, 8'h04};
    start_req(8'h80, 8'h06, 16'h0300, 16'h0409, 16'h00FF);
    tick();
    collect(8);
    checks++; if (nbeats !== 4) begin errors++; $display("FAIL str_beats: got %0d expected 4", nbeats); end
    for (int i = 0; i < 4 && i < nbeats; i++) begin
      checks++; if (got_data[i] !== exp_s[i] || got_last[i] !== (i == 3)) begin
        errors++; $display("FAIL str_beat%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_s[i], (i == 3));
      end
    end
    end_req();
    start_req(8'h80, 8'h06, 16'h0301, 16'h0409, 16'h00FF);
    tick();
    checks++; if (ctl_xfer_stall_o !== 1'b1 || ctl_xfer_gnt_o !== 1'b0) begin errors++; $display("FAIL str_bad: got stall %b gnt %b expected 1/0", ctl_xfer_stall_o, ctl_xfer_gnt_o); end
    end_req();
    checks++; if (ctl_xfer_stall_o !== 1'b0) begin errors++; $display("FAIL str_stall_drop: got %b expected 0", ctl_xfer_stall_o); end
  endtask

  task automatic test_qualifier();
    logic [7:0] exp_q [0:9] = '{8'h0A, 8'h06, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h01, 8'h00};
    start_req(8'h80, 8'h06, 16'h0600, 16'h0000, 16'h0040);
    tick();
    collect(14);
    checks++; if (nbeats !== 10) begin errors++; $display("FAIL qual_beats: got %0d expected 10", nbeats); end
    for (int i = 0; i < 10 && i < nbeats; i++) begin
      checks++; if (got_data[i] !== exp_q[i] || got_last[i] !== (i == 9)) begin
        errors++; $display("FAIL qual_beat%0d: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_q[i], (i == 9));
      end
    end
    end_req();
  endtask

  task automatic test_set_address();
    start_req(8'h00, 8'h05, 16'h002A, 16'h0000, 16'h0000);
    tick();
    checks++; if (ctl_xfer_gnt_o !== 1'b1 || ctl_tvalid_o !== 1'b0) begin errors++; $display("FAIL addr_gnt: got %b/%b expected 1/0", ctl_xfer_gnt_o, ctl_tvalid_o); end
    repeat (3) tick();
    checks++; if (device_address !== 7'd0) begin errors++; $display("FAIL addr_early: got %h expected 00", device_address); end
    end_req();
    checks++; if (device_address !== 7'h2A) begin errors++; $display("FAIL addr_commit: got %h expected 2a", device_address); end
    start_req(8'h00, 8'h05, 16'h0080, 16'h0000, 16'h0000);
    tick();
    checks++; if (ctl_xfer_stall_o !== 1'b1) begin errors++; $display("FAIL addr_big: got stall %b expected 1", ctl_xfer_stall_o); end
    end_req();
    checks++; if (device_address !== 7'h2A) begin errors++; $display("FAIL addr_keep: got %h expected 2a", device_address); end
  endtask

  task automatic test_set_config();
    start_req(8'h00, 8'h09, 16'h0001, 16'h0000, 16'h0000);
    tick();
    checks++; if (ctl_xfer_gnt_o !== 1'b1 || configured !== 1'b0) begin errors++; $display("FAIL setcfg_pending: got gnt %b cfg %b expected 1/0", ctl_xfer_gnt_o, configured); end
    end_req();
    checks++; if (configured !== 1'b1 || current_configuration !== 8'h01) begin errors++; $display("FAIL setcfg_commit: got %b/%h expected 1/01", configured, current_configuration); end
    start_req(8'h80, 8'h08, 16'h0000, 16'h0000, 16'h0001);
    tick();
    collect(4);
    checks++; if (nbeats !== 1 || got_data[0] !== 8'h01 || got_last[0] !== 1'b1) begin errors++; $display("FAIL getcfg: got %0d beats %h last %b expected 1 beat 01 last 1", nbeats, got_data[0], got_last[0]); end
    end_req();
    start_req(8'h00, 8'h09, 16'h0005, 16'h0000, 16'h0000);
    tick();
    checks++; if (ctl_xfer_stall_o !== 1'b1 || ctl_xfer_gnt_o !== 1'b0) begin errors++; $display("FAIL setcfg_bad: got stall %b gnt %b expected 1/0", ctl_xfer_stall_o, ctl_xfer_gnt_o); end
    end_req();
    checks++; if (configured !== 1'b1 || current_configuration !== 8'h01) begin errors++; $display("FAIL setcfg_keep: got %b/%h expected 1/01", configured, current_configuration); end
    start_req(8'h00, 8'h05, 16'h0010, 16'h0000, 16'h0000);
    tick();
    checks++; if (ctl_xfer_stall_o !== 1'b1) begin errors++; $display("FAIL addr_configured: got stall %b expected 1", ctl_xfer_stall_o); end
    end_req();
  endtask

  task automatic test_interface();
    start_req(8'h01, 8'h0B, 16'h0002, 16'h0001, 16'h0000);
    tick();
    checks++; if (ctl_xfer_gnt_o !== 1'b1 || alt_settings_o !== 8'h00) begin errors++; $display("FAIL setif_pending: got gnt %b alt %h expected 1/00", ctl_xfer_gnt_o, alt_settings_o); end
    end_req();
    checks++; if (alt_settings_o !== 8'h20) begin errors++; $display("FAIL setif_commit: got %h expected 20", alt_settings_o); end
    start_req(8'h81, 8'h0A, 16'h0000, 16'h0001, 16'h0001);
    tick();
    collect(4);
    checks++; if (nbeats !== 1 || got_data[0] !== 8'h02) begin errors++; $display("FAIL getif: got %0d beats %h expected 1 beat 02", nbeats, got_data[0]); end
    end_req();
    start_req(8'h01, 8'h0B, 16'h0004, 16'h0000, 16'h0000);
    tick();
    checks++; if (ctl_xfer_stall_o !== 1'b1) begin errors++; $display("FAIL setif_maxalt: got stall %b expected 1", ctl_xfer_stall_o); end
    end_req();
    start_req(8'h81, 8'h0A, 16'h0000, 16'h0002, 16'h0001);
    tick();
    checks++; if (ctl_xfer_stall_o !== 1'b1) begin errors++; $display("FAIL getif_range: got stall %b expected 1", ctl_xfer_stall_o); end
    end_req();
  endtask

  task automatic test_feature_status();
    start_req(8'h00, 8'h03, 16'h0001, 16'h0000, 16'h0000);
    tick();
    checks++; if (ctl_xfer_gnt_o !== 1'b1 || remote_wakeup_o !== 1'b0) begin errors++; $display("FAIL wake_pending: got gnt %b rw %b expected 1/0", ctl_xfer_gnt_o, remote_wakeup_o); end
    end_req();
    checks++; if (remote_wakeup_o !== 1'b1) begin errors++; $display("FAIL wake_set: got %b expected 1", remote_wakeup_o); end
    start_req(8'h80, 8'h00, 16'h0000, 16'h0000, 16'h0002);
    tick();
    collect(5);
    checks++; if (nbeats !== 2 || got_data[0] !== 8'h03 || got_data[1] !== 8'h00 || got_last[1] !== 1'b1) begin
      errors++; $display("FAIL status_dev: got %0d beats %h %h last %b expected 2 beats 03 00 last 1", nbeats, got_data[0], got_data[1], got_last[1]);
    end
    end_req();
    start_req(8'h81, 8'h00, 16'h0000, 16'h0002, 16'h0002);
    tick();
    checks++; if (ctl_xfer_stall_o !== 1'b1 || ctl_xfer_gnt_o !== 1'b0) begin errors++; $display("FAIL status_if_range: got stall %b gnt %b expected 1/0", ctl_xfer_stall_o, ctl_xfer_gnt_o); end
    end_req();
    start_req(8'h00, 8'h01, 16'h0001, 16'h0000, 16'h0000);
    end_req();
    checks++; if (remote_wakeup_o !== 1'b0) begin errors++; $display("FAIL wake_clear: got %b expected 0", remote_wakeup_o); end
    start_req(8'h00, 8'h03, 16'h0001, 16'h0000, 16'h0000);
    end_req();
  endtask

  task automatic test_reset_mid_send();
    start_req(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040);
    ctl_tready_i = 1'b1;
    tick();
    repeat (4) tick();
    checks++; if (ctl_tvalid_o !== 1'b1 || ctl_tdata_o !== 8'h14) begin errors++; $display("FAIL rst_beat4: got %b/%h expected 1/14", ctl_tvalid_o, ctl_tdata_o); end
    reset_n = 1'b0;
    #1;
    checks++; if (ctl_tvalid_o !== 1'b0 || ctl_xfer_gnt_o !== 1'b0 || ctl_tlast_o !== 1'b0) begin errors++; $display("FAIL rst_abort: got tvalid %b gnt %b tlast %b expected 000", ctl_tvalid_o, ctl_xfer_gnt_o, ctl_tlast_o); end
    checks++; if (device_address !== 7'd0 || configured !== 1'b0 || current_configuration !== 8'd0) begin errors++; $display("FAIL rst_state: got %h/%b/%h expected 00/0/00", device_address, configured, current_configuration); end
    checks++; if (alt_settings_o !== 8'h00 || remote_wakeup_o !== 1'b0) begin errors++; $display("FAIL rst_alt_wake: got %h/%b expected 00/0", alt_settings_o, remote_wakeup_o); end
    @(negedge clock);
    ctl_xfer_req_i = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_vendor();
    start_req(8'h40, 8'h01, 16'h0000, 16'h0000, 16'h0010);
    #1;
    checks++; if (standard_request !== 1'b0) begin errors++; $display("FAIL vendor_stdreq: got %b expected 0", standard_request); end
    repeat (3) tick();
    checks++; if (ctl_xfer_gnt_o !== 1'b0 || ctl_xfer_stall_o !== 1'b0) begin errors++; $display("FAIL vendor_ignore: got gnt %b stall %b expected 0/0", ctl_xfer_gnt_o, ctl_xfer_stall_o); end
    ctl_xfer_type = 8'h80;
    ctl_xfer_endpoint = 4'd1;
    #1;
    checks++; if (standard_request !== 1'b0) begin errors++; $display("FAIL ep1_stdreq: got %b expected 0", standard_request); end
    ctl_xfer_req_i = 1'b0;
    ctl_xfer_endpoint = 4'd0;
    tick();
  endtask

  initial begin
    test_reset();
    test_get_device_desc();
    test_get_config_desc();
    test_backpressure();
    test_strings();
    test_qualifier();
    test_set_address();
    test_set_config();
    test_interface();
    test_feature_status();
    test_reset_mid_send();
    test_vendor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
